// File: rtl/count_step_gen.sv
// -----------------------------------------------------------------------------
// count_step_gen
//
// Produces the single-cycle step commands (en + inc or en + dec) for one
// count_gate instance. There are two sources:
//   - run mode (mode = 0): every prescaler tick becomes one increment step.
//   - set mode (mode = 1): debounced up/down buttons give one step on press,
//     then auto-repeat steps while the button is held.
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   mode       0 = run (tick-driven), 1 = set (button-driven), clk-synchronous
//   tick       single-cycle prescaler strobe, clk-synchronous
//   btn_up     raw up button, active-high, asynchronous
//   btn_dn     raw down button, active-high, asynchronous
//   en         step strobe            -> count_gate.en
//   inc        increment select       -> count_gate.inc
//   dec        decrement select       -> count_gate.dec
//   repeating  high while auto-repeat is active
//
// All outputs are registered. A step is exactly one cycle with en = 1 and
// exactly one of inc/dec = 1; otherwise en = inc = dec = 0.
// -----------------------------------------------------------------------------
module count_step_gen #(
  parameter int SYNC_STAGES   = 2,   // synchroniser depth per button (>= 2)
  parameter int DEB_CYCLES    = 16,  // stable samples to change a debounced level
  parameter int HOLD_CYCLES   = 64,  // first step to first auto-repeat step
  parameter int REPEAT_CYCLES = 16,  // spacing of auto-repeat steps
  parameter int TMR_W         = 8    // timer width, holds the largest count above
) (
  input  logic clk,
  input  logic reset_n,
  input  logic mode,
  input  logic tick,
  input  logic btn_up,
  input  logic btn_dn,
  output logic en,
  output logic inc,
  output logic dec,
  output logic repeating
);

  // Terminal timer values, sized to the timer width.
  localparam logic [TMR_W-1:0] DEB_LAST  = TMR_W'(DEB_CYCLES - 1);
  localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] REP_LAST  = TMR_W'(REPEAT_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);

  // ---------------------------------------------------------------------------
  // Button conditioning: index 0 = up, index 1 = down.
  // ---------------------------------------------------------------------------
  logic [1:0] btn_raw;
  logic [1:0] btn_sync;
  logic [1:0] btn_db;

  assign btn_raw = {btn_dn, btn_up};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
      logic [SYNC_STAGES-1:0] sync_q;
      logic                   db_q;
      logic                   db_d;
      logic [TMR_W-1:0]       deb_cnt_q;
      logic [TMR_W-1:0]       deb_cnt_d;

      // Plain shift-register synchroniser; stage 0 sees the raw pad.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          sync_q <= '0;
        end else begin
          sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw[gi]};
        end
      end

      assign btn_sync[gi] = sync_q[SYNC_STAGES-1];

      // The counter measures how long the synchronised level has disagreed
      // with the debounced level. Any agreement restarts it, so only a run of
      // DEB_CYCLES consecutive disagreeing samples flips the debounced level.
      always_comb begin
        db_d      = db_q;
        deb_cnt_d = '0;
        if (btn_sync[gi] != db_q) begin
          if (deb_cnt_q >= DEB_LAST) begin
            db_d      = ~db_q;
            deb_cnt_d = '0;
          end else begin
            deb_cnt_d = deb_cnt_q + TMR_ONE;
          end
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          db_q      <= 1'b0;
          deb_cnt_q <= '0;
        end else begin
          db_q      <= db_d;
          deb_cnt_q <= deb_cnt_d;
        end
      end

      assign btn_db[gi] = db_q;
    end
  endgenerate

  logic up_db;
  logic dn_db;

  assign up_db = btn_db[0];
  assign dn_db = btn_db[1];

  // ---------------------------------------------------------------------------
  // Run-mode path: tick is registered once, then turned into a step on the
  // following edge by the output register below.
  // ---------------------------------------------------------------------------
  logic tick_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= tick & ~mode;
    end
  end

  // ---------------------------------------------------------------------------
  // Set-mode FSM with registered outputs.
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_LOCK,
    ST_IDLE,
    ST_WAIT_HOLD,
    ST_REPEAT
  } state_t;

  state_t           state_q;
  logic             dir_dn_q;   // latched direction: 0 = up, 1 = down
  logic [TMR_W-1:0] tmr_q;
  logic             en_q;
  logic             inc_q;
  logic             dec_q;
  logic             rep_q;

  // Latched button and the opposite button, relative to the held direction.
  logic held_db;
  logic other_db;

  assign held_db  = dir_dn_q ? dn_db : up_db;
  assign other_db = dir_dn_q ? up_db : dn_db;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_LOCK;
      dir_dn_q <= 1'b0;
      tmr_q    <= '0;
      en_q     <= 1'b0;
      inc_q    <= 1'b0;
      dec_q    <= 1'b0;
      rep_q    <= 1'b0;
    end else begin
      // Strobe outputs are low unless a step is issued this edge.
      en_q  <= 1'b0;
      inc_q <= 1'b0;
      dec_q <= 1'b0;
      rep_q <= 1'b0;

      // tick_q is only ever set while mode was 0, and the FSM is held in
      // LOCK on that same edge, so a run step can never meet a button step.
      if (tick_q) begin
        en_q  <= 1'b1;
        inc_q <= 1'b1;
      end

      if (!mode) begin
        // Run mode owns the outputs; buttons are ignored entirely.
        state_q <= ST_LOCK;
        tmr_q   <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (up_db && dn_db) begin
              state_q <= ST_LOCK;
            end else if (up_db ^ dn_db) begin
              en_q     <= 1'b1;
              inc_q    <= up_db;
              dec_q    <= dn_db;
              dir_dn_q <= dn_db;
              tmr_q    <= '0;
              state_q  <= ST_WAIT_HOLD;
            end
          end

          ST_WAIT_HOLD: begin
            // Exit conditions take priority over a timer expiring on the
            // same cycle, so no step leaks out on release.
            if (!held_db) begin
              state_q <= ST_IDLE;
            end else if (other_db) begin
              state_q <= ST_LOCK;
            end else if (tmr_q >= HOLD_LAST) begin
              en_q    <= 1'b1;
              inc_q   <= ~dir_dn_q;
              dec_q   <= dir_dn_q;
              tmr_q   <= '0;
              rep_q   <= 1'b1;
              state_q <= ST_REPEAT;
            end else begin
              tmr_q <= tmr_q + TMR_ONE;
            end
          end

          ST_REPEAT: begin
            if (!held_db) begin
              state_q <= ST_IDLE;
            end else if (other_db) begin
              state_q <= ST_LOCK;
            end else begin
              rep_q <= 1'b1;
              if (tmr_q >= REP_LAST) begin
                en_q  <= 1'b1;
                inc_q <= ~dir_dn_q;
                dec_q <= dir_dn_q;
                tmr_q <= '0;
              end else begin
                tmr_q <= tmr_q + TMR_ONE;
              end
            end
          end

          ST_LOCK: begin
            // Leave only after a full release of both buttons.
            if (!up_db && !dn_db) begin
              state_q <= ST_IDLE;
            end
          end

          default: begin
            state_q <= ST_LOCK;
          end
        endcase
      end
    end
  end

  assign en        = en_q;
  assign inc       = inc_q;
  assign dec       = dec_q;
  assign repeating = rep_q;

endmodule

// File: tb/tb_count_step_gen.sv
// -----------------------------------------------------------------------------
// tb_count_step_gen
//
// Directed bench for count_step_gen with SYNC_STAGES=2, DEB_CYCLES=4,
// HOLD_CYCLES=8, REPEAT_CYCLES=3. Inputs are driven 1 ns after a rising
// edge (that edge is cycle 0 of a scenario); outputs are sampled 1 ns after
// each following rising edge, so "cycle k" is the interval after edge k.
// Expected step cycles are worked out by hand from the pipeline:
// 2 sync stages + 4 debounce samples + 1 output register = step in cycle 7.
// -----------------------------------------------------------------------------
module tb_count_step_gen;

  logic clk;
  logic reset_n;
  logic mode;
  logic tick;
  logic btn_up;
  logic btn_dn;
  logic en;
  logic inc;
  logic dec;
  logic repeating;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int base     = 0;
  int enc_bad  = 0;
  int rep_first;
  int step_cyc[$];
  int step_dir[$];   // 1 = inc, 2 = dec, 0 = neither
  int exp_q[$];

  count_step_gen #(
    .SYNC_STAGES  (2),
    .DEB_CYCLES   (4),
    .HOLD_CYCLES  (8),
    .REPEAT_CYCLES(3),
    .TMR_W        (8)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .mode     (mode),
    .tick     (tick),
    .btn_up   (btn_up),
    .btn_dn   (btn_dn),
    .en       (en),
    .inc      (inc),
    .dec      (dec),
    .repeating(repeating)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one cycle and log what the outputs did during it.
  task automatic clk_cycle();
    @(posedge clk);
    #1;
    cyc++;
    if (en === 1'b1) begin
      step_cyc.push_back(cyc - base);
      step_dir.push_back(dec ? 2 : (inc ? 1 : 0));
    end
    if ((en && (inc == dec)) || (!en && (inc || dec))) enc_bad++;
    if (repeating === 1'b1 && rep_first < 0) rep_first = cyc - base;
  endtask

  task automatic run(input int n);
    repeat (n) clk_cycle();
  endtask

  task automatic start_log();
    step_cyc.delete();
    step_dir.delete();
    rep_first = -1;
    base      = cyc;
  endtask

  // Compare logged steps against exp_q, all expected in direction dir.
  task automatic check_steps(input string tag, input int dir);
    check_val({tag, "_count"}, step_cyc.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < step_cyc.size(); i++) begin
      check_val($sformatf("%s_cyc%0d", tag, i), step_cyc[i], exp_q[i]);
      check_val($sformatf("%s_dir%0d", tag, i), step_dir[i], dir);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    mode    = 1'b1;
    tick    = 1'b0;
    btn_up  = 1'b0;
    btn_dn  = 1'b0;
    rep_first = -1;

    // Reset state.
    run(3);
    check_val("rst_en", en, 0);
    check_val("rst_inc", inc, 0);
    check_val("rst_dec", dec, 0);
    check_val("rst_rep", repeating, 0);
    reset_n = 1'b1;
    run(5);

    // Short tap, released before the hold timer can expire: one up step.
    start_log();
    btn_up = 1'b1;
    run(6);
    btn_up = 1'b0;
    run(20);
    exp_q = {7};
    check_steps("tap", 1);
    check_val("tap_rep", rep_first, -1);

    // Release detected on the very cycle the hold timer expires: no step.
    start_log();
    btn_up = 1'b1;
    run(8);
    btn_up = 1'b0;
    run(20);
    exp_q = {7};
    check_steps("rel_edge", 1);

    // One cycle longer: the hold timer wins, second step at 15.
    start_log();
    btn_up = 1'b1;
    run(9);
    btn_up = 1'b0;
    run(20);
    exp_q = {7, 15};
    check_steps("rel_late", 1);
    check_val("rel_late_rep", rep_first, 15);

    // Long down hold: first step, hold step, then repeat every 3 cycles.
    start_log();
    btn_dn = 1'b1;
    run(30);
    btn_dn = 1'b0;
    run(20);
    exp_q = {7, 15, 18, 21, 24, 27, 30, 33, 36};
    check_steps("hold", 2);
    check_val("hold_rep_first", rep_first, 15);
    check_val("hold_rep_end", repeating, 0);

    // Glitch shorter than the debounce window: nothing.
    start_log();
    btn_up = 1'b1;
    run(3);
    btn_up = 1'b0;
    run(15);
    exp_q.delete();
    check_steps("glitch", 1);

    // Up held, down added: LOCK after the first step, stays locked until
    // both are released.
    start_log();
    btn_up = 1'b1;
    run(5);
    btn_dn = 1'b1;
    run(25);
    btn_dn = 1'b0;
    run(20);
    btn_up = 1'b0;
    run(20);
    exp_q = {7};
    check_steps("both", 1);

    // Fresh press after full release steps again.
    start_log();
    btn_up = 1'b1;
    run(6);
    btn_up = 1'b0;
    run(20);
    exp_q = {7};
    check_steps("repress", 1);

    // Run mode: ticks in cycles 5, 9, 10 with buttons busy meanwhile.
    start_log();
    mode   = 1'b0;
    btn_dn = 1'b1;
    for (int r = 0; r < 25; r++) begin
      tick   = (r == 5 || r == 9 || r == 10);
      btn_up = ((r / 3) % 2) == 1;
      clk_cycle();
    end
    tick   = 1'b0;
    btn_up = 1'b0;
    btn_dn = 1'b0;
    run(15);
    exp_q = {7, 11, 12};
    check_steps("run", 1);

    // Back to set mode with a button already held: no step until release.
    start_log();
    btn_up = 1'b1;
    run(15);
    mode = 1'b1;
    run(20);
    exp_q.delete();
    check_steps("mode_held", 1);
    btn_up = 1'b0;
    run(15);

    // Re-press into REPEAT, then reset asynchronously mid-step.
    start_log();
    btn_up = 1'b1;
    run(21);
    check_val("pre_rst_en", en, 1);
    check_val("pre_rst_rep", repeating, 1);
    #1;
    reset_n = 1'b0;
    #1;
    check_val("async_rst_en", en, 0);
    check_val("async_rst_inc", inc, 0);
    check_val("async_rst_dec", dec, 0);
    check_val("async_rst_rep", repeating, 0);
    exp_q = {7, 15, 18, 21};
    check_steps("repeat", 1);
    btn_up = 1'b0;
    run(3);
    reset_n = 1'b1;
    run(10);

    // After reset the generator works normally again.
    start_log();
    btn_dn = 1'b1;
    run(6);
    btn_dn = 1'b0;
    run(20);
    exp_q = {7};
    check_steps("post_rst", 2);

    check_val("step_encoding", enc_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Scenario lengths are all fixed, so this only trips if time runs away.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
